// File: rtl/game_round_ctrl.sv
// Round sequencer for the target game: requests a fresh target each round,
// opens a timed shot window, scores hits and counts rounds until the game ends.
module game_round_ctrl #(
    parameter int ROUNDS  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       shot_valid,
    input  logic [4:0] shot_x,
    input  logic [4:0] shot_y,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic       next_target,
    output logic       round_active,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [7:0] round_num,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE, LOAD, ARM, WAIT_SHOT, RESULT, DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] timer, timer_nx;
    logic [7:0]  score_nx, round_nx;
    logic        hit_flag, hit_nx;
    logic        miss_flag, miss_nx;
    logic        on_target;

    assign on_target = (shot_x == target_x) && (shot_y == target_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            score     <= '0;
            round_num <= '0;
            hit_flag  <= 1'b0;
            miss_flag <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            score     <= score_nx;
            round_num <= round_nx;
            hit_flag  <= hit_nx;
            miss_flag <= miss_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        score_nx = score;
        round_nx = round_num;
        hit_nx   = hit_flag;
        miss_nx  = miss_flag;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    score_nx = '0;
                    round_nx = '0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                hit_nx   = 1'b0;
                miss_nx  = 1'b0;
                state_nx = ARM;
            end
            ARM: begin
                timer_nx = 16'(TIMEOUT);
                state_nx = WAIT_SHOT;
            end
            WAIT_SHOT: begin
                // A shot on the final timer cycle still counts as a shot.
                if (shot_valid && on_target) begin
                    hit_nx   = 1'b1;
                    if (score != 8'hFF)
                        score_nx = score + 8'd1;
                    state_nx = RESULT;
                end else if (shot_valid) begin
                    miss_nx  = 1'b1;
                    state_nx = RESULT;
                end else if (timer == 16'd0) begin
                    miss_nx  = 1'b1;
                    state_nx = RESULT;
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            RESULT: begin
                round_nx = round_num + 8'd1;
                hit_nx   = 1'b0;
                miss_nx  = 1'b0;
                state_nx = (round_nx == 8'(ROUNDS)) ? DONE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign next_target  = (state == LOAD);
    assign round_active = (state == WAIT_SHOT);
    assign hit          = (state == RESULT) && hit_flag;
    assign miss         = (state == RESULT) && miss_flag;
    assign game_over    = (state == DONE);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with ROUNDS=3, TIMEOUT=7 and a
// behavioural target generator that steps on every next_target pulse.
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       shot_valid = 1'b0;
    logic [4:0] shot_x = '0, shot_y = '0;
    logic [4:0] target_x, target_y;
    logic       next_target, round_active, hit, miss, game_over;
    logic [7:0] score, round_num;

    int n_chk = 0, n_fail = 0;
    int n_nt = 0, n_hit = 0, n_miss = 0;
    logic [3:0] tidx = '0;

    game_round_ctrl #(.ROUNDS(3), .TIMEOUT(7)) dut (
        .clk(clk), .reset(reset), .start(start), .shot_valid(shot_valid),
        .shot_x(shot_x), .shot_y(shot_y), .target_x(target_x), .target_y(target_y),
        .next_target(next_target), .round_active(round_active), .hit(hit),
        .miss(miss), .score(score), .round_num(round_num), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Generator stand-in: new target at the end of each next_target cycle.
    always @(posedge clk) if (next_target) tidx <= tidx + 4'd1;
    always_comb begin
        target_x = 5'((tidx * 7 + 3) % 32);
        target_y = {4'b0, tidx[0]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (next_target) n_nt++;
        if (hit) n_hit++;
        if (miss) n_miss++;
    endtask

    task automatic wait_active();
        int k = 0;
        while (!round_active && k < 40) begin
            tick();
            k++;
        end
        chk("wait_active", round_active, 1);
    endtask

    task automatic fire(input logic [4:0] x, input logic [4:0] y);
        shot_x = x;
        shot_y = y;
        shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nt0, hit0, len;
        logic bad;

        // Reset and idle quiet
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_score", score, 0);
        chk("rst_round", round_num, 0);
        chk("rst_outs", {next_target, round_active, hit, miss, game_over}, 0);
        bad = 1'b0;
        repeat (10) begin
            shot_valid = 1'($urandom_range(0, 1));
            shot_x = target_x;
            shot_y = target_y;
            tick();
            bad |= next_target | round_active | hit | miss | game_over | (|score) | (|round_num);
        end
        shot_valid = 1'b0;
        chk("idle_quiet", bad, 0);

        // All-hit game, with start latency checks
        nt0 = n_nt; hit0 = n_hit;
        pulse_start();
        chk("start_load", next_target, 1);
        tick();
        chk("arm_inactive", {next_target, round_active}, 0);
        tick();
        chk("active_n3", round_active, 1);
        for (int r = 0; r < 3; r++) begin
            wait_active();
            repeat (2) tick();
            fire(target_x, target_y);
            chk("g1_hit", {hit, miss, round_active}, 3'b100);
            chk("g1_score", score, r + 1);
            tick();
            chk("g1_round", round_num, r + 1);
            if (r < 2) chk("g1_next", next_target, 1);
            else       chk("g1_over", game_over, 1);
        end
        chk("g1_nt_pulses", n_nt - nt0, 3);
        chk("g1_hit_pulses", n_hit - hit0, 3);

        // Timeout-only game, starting directly from DONE
        pulse_start();
        chk("g2_clr", {score, round_num}, 0);
        chk("g2_load", next_target, 1);
        for (int r = 0; r < 3; r++) begin
            wait_active();
            len = 0;
            while (round_active && len < 40) begin
                len++;
                tick();
            end
            chk("g2_window", len, 8);
            chk("g2_miss", {hit, miss}, 2'b01);
            tick();
        end
        chk("g2_final", {score, round_num, 7'b0, game_over}, {8'd0, 8'd3, 8'd1});

        // Partial match miss, last-cycle hit, then a plain hit
        pulse_start();
        wait_active();
        tick();
        fire(target_x, target_y ^ 5'd1);
        chk("g3_ymiss", {hit, miss}, 2'b01);
        chk("g3_ymiss_score", score, 0);
        tick();
        wait_active();
        repeat (7) tick();
        chk("g3_last_cycle", round_active, 1);
        fire(target_x, target_y);
        chk("g3_edge_hit", {hit, miss}, 2'b10);
        chk("g3_edge_score", score, 1);
        tick();
        wait_active();
        tick();
        fire(target_x, target_y);
        chk("g3_score", score, 2);
        tick();
        chk("g3_done", {round_num, 7'b0, game_over}, {8'd3, 8'd1});
        shot_x = target_x;
        shot_y = target_y;
        shot_valid = 1'b1;
        repeat (2) tick();
        shot_valid = 1'b0;
        chk("g3_stray_shot", {score, round_num, 7'b0, game_over}, {8'd2, 8'd3, 8'd1});

        // Restart from DONE with score=2, then reset mid-window of round 2
        pulse_start();
        chk("g4_clr", {score, round_num}, 0);
        chk("g4_load", next_target, 1);
        wait_active();
        repeat (2) tick();
        fire(target_x, target_y);
        chk("g4_r1_score", score, 1);
        tick();
        wait_active();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_cnt", {score, round_num}, 0);
        chk("rst_mid_outs", {next_target, round_active, hit, miss, game_over}, 0);
        tick();
        chk("rst_mid_idle", {next_target, round_active, hit, miss, game_over}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the target game. Drives the target generator's advance/enable input, so each round gets a fresh pseudo-random target. Arms a per-round shot window, compares the player's shot against the registered target, and keeps score and round count until a game of `ROUNDS` rounds completes. Sits between the player-input logic and the target generator.

## Interface

Parameters:
- `ROUNDS`, default 8. Rounds per game; legal range 1..255.
- `TIMEOUT`, default 1023. Timer reload value; legal range 1..65535. The shot window is `TIMEOUT+1` cycles.

Ports:
- `clk`  in  1. Single clock; everything is rising-edge.
- `reset`  in  1. Synchronous, active-high. Returns the block to IDLE and clears all state.
- `start`  in  1. Begins a game. Sampled only in IDLE and DONE.
- `shot_valid`  in  1. One-cycle shot strobe from player logic.
- `shot_x`  in  5. Shot X coordinate.
- `shot_y`  in  5. Shot Y coordinate.
- `target_x`  in  5. Current target X, from the generator.
- `target_y`  in  5. Current target Y, from the generator.
- `next_target`  out  1. One-cycle pulse; connects to the generator's enable (`result_valid`).
- `round_active`  out  1. High while the shot window is open.
- `hit`  out  1. One-cycle pulse; the round ended with a matching shot.
- `miss`  out  1. One-cycle pulse; the round ended with a wrong shot or a timeout.
- `score`  out  8. Hits in the current or last game; saturates at 255.
- `round_num`  out  8. Number of completed rounds in the current or last game.
- `game_over`  out  1. High in DONE.

## Operation

- States: IDLE, LOAD, ARM, WAIT_SHOT, RESULT, DONE.
- IDLE: all outputs 0. `start`=1 clears `score` and `round_num`, then goes to LOAD.
- LOAD (1 cycle): `next_target`=1. The generator updates its target at the end of this cycle. Next state is ARM.
- ARM (1 cycle): the target inputs are now stable. Load `timer` (16 bits) with `TIMEOUT`. Next state is WAIT_SHOT.
- WAIT_SHOT: `round_active`=1. Evaluate in this priority order:
  - `shot_valid`=1 and (`shot_x`,`shot_y`)==(`target_x`,`target_y`): set the hit flag, `score`+1 (saturating at 255), go to RESULT.
  - `shot_valid`=1 and the coordinates do not match: set the miss flag, go to RESULT.
  - `timer`==0: set the miss flag, go to RESULT.
  - Otherwise: `timer`-1 and stay in WAIT_SHOT.
- A shot in the same cycle that `timer` reaches 0 is evaluated as a shot; the shot wins over the timeout.
- RESULT (1 cycle): `hit` or `miss`=1 (exactly one of them). `round_num`+1. If the new `round_num`==`ROUNDS`, go to DONE; otherwise go to LOAD.
- DONE: `game_over`=1. `score` and `round_num` hold their values. `start`=1 clears both and goes to LOAD (no pass through IDLE).
- `shot_valid` outside WAIT_SHOT is ignored: no effect on score, round or state.
- `start` outside IDLE/DONE is ignored.
- Compare all 5 bits of each coordinate exactly. The generator drives only values 0/1 on `target_y`; do not special-case this.

## Timing

- Reset values: state=IDLE, `timer`=0, `score`=0, `round_num`=0, and every output 0.
- `reset` overrides everything in the same edge, including mid-round. It does not itself pulse `next_target`; the generator has its own reset.
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- `start` sampled high at edge N: LOAD during cycle N+1, ARM during N+2, `round_active` high from N+3.
- Shot accepted at edge M: `round_active` drops and `hit`/`miss` rises in cycle M+1. `score` and `round_num` are updated as seen in cycle M+1 (score) and M+2 (round_num). `next_target` pulses in cycle M+2 if the game is not finished.
- Timeout with no shot: WAIT_SHOT lasts exactly `TIMEOUT+1` cycles, then `miss` follows.
- Round cycle cost: 2 + (cycles in WAIT_SHOT) + 1.
- Exactly one `next_target` pulse per round. Exactly `ROUNDS` pulses per game.

## Test plan

All scenarios use `ROUNDS`=3 and `TIMEOUT`=7.

- Reset, then idle for 10 cycles with random `shot_valid` -> all outputs stay 0, `score`=0, `round_num`=0.
- `start` pulse; each round, shoot the current target 2 cycles after `round_active` rises -> 3 `hit` pulses, 3 `next_target` pulses, `score`=3, `round_num`=3, `game_over`=1.
- `start`; never shoot -> each WAIT_SHOT lasts exactly 8 cycles, then `miss`; final `score`=0, `round_num`=3.
- `shot_valid` with `shot_x`=`target_x` but `shot_y`≠`target_y` -> `miss`, score unchanged. A shot on the same cycle `timer` hits 0 that matches the target -> `hit`, not `miss`.
- Assert `reset` mid-WAIT_SHOT of round 2 -> next cycle state=IDLE, `score`=0, `round_num`=0, `round_active`=0, no `hit`/`miss` pulse.
- In DONE with `score`=2, pulse `start` -> `score`/`round_num` clear to 0, `next_target` pulses the following cycle, and a new game runs.
